// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one partial product per cycle through a single Adder.
// Define SEQ_MUL_ACC_EN to add the acc port and the ACC_LO/ACC_HI states (product = a*b + acc).

module Adder #(
    parameter int n = 32
) (
    input  logic [n-1:0] x_i,
    input  logic [n-1:0] y_i,
    input  logic         cin_i,
    output logic [n-1:0] z_o,
    output logic         cout_o
);
    assign {cout_o, z_o} = {1'b0, x_i} + {1'b0, y_i} + {{n{1'b0}}, cin_i};
endmodule

module seq_multiplier #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [n-1:0]   a_i,
    input  logic [n-1:0]   b_i,
`ifdef SEQ_MUL_ACC_EN
    input  logic [n-1:0]   acc_i,
`endif
    output logic           ready_o,
    output logic           done_o,
    output logic [2*n-1:0] product_o
);
    localparam int CW = $clog2(n) + 1;

`ifdef SEQ_MUL_ACC_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, RUN = 3'd1, ACC_LO = 3'd2, ACC_HI = 3'd3, DONE = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [n-1:0]   m_q, m_d;
    logic [2*n:0]   p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*n-1:0] product_q, product_d;
    logic           ready_q, done_q;
`ifdef SEQ_MUL_ACC_EN
    logic [n-1:0]   acc_q, acc_d;
`endif

    logic [n-1:0]   add_x_s, add_y_s, add_z_s;
    logic           add_cin_s, add_cout_s;

    Adder #(.n(n)) u_adder (
        .x_i    (add_x_s),
        .y_i    (add_y_s),
        .cin_i  (add_cin_s),
        .z_o    (add_z_s),
        .cout_o (add_cout_s)
    );

    // Next-state, datapath steering and product capture.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef SEQ_MUL_ACC_EN
        acc_d     = acc_q;
`endif
        add_x_s   = p_q[2*n-1:n];
        add_y_s   = {n{1'b0}};
        // P's top bit holds the saved low-half carry; it is zero everywhere except entering ACC_HI.
        add_cin_s = p_q[2*n];

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    p_d     = {1'b0, {n{1'b0}}, b_i};
                    m_d     = a_i;
                    cnt_d   = CW'(n);
`ifdef SEQ_MUL_ACC_EN
                    acc_d   = acc_i;
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                add_y_s = p_q[0] ? m_q : {n{1'b0}};
                p_d     = {1'b0, add_cout_s, add_z_s, p_q[n-1:1]};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef SEQ_MUL_ACC_EN
                    state_d = ACC_LO;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RUN;
                end
            end
`ifdef SEQ_MUL_ACC_EN
            ACC_LO: begin
                add_x_s      = p_q[n-1:0];
                add_y_s      = acc_q;
                p_d[n-1:0]   = add_z_s;
                p_d[2*n]     = add_cout_s;
                state_d      = ACC_HI;
            end
            ACC_HI: begin
                p_d[2*n-1:n] = add_z_s;
                p_d[2*n]     = 1'b0;
                state_d      = ACC_HI == ACC_HI ? DONE : DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == DONE) && (state_q != DONE)) begin
            product_d = p_d[2*n-1:0];
        end else begin
            product_d = product_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= {n{1'b0}};
            p_q       <= {(2*n+1){1'b0}};
            cnt_q     <= {CW{1'b0}};
            product_q <= {(2*n){1'b0}};
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef SEQ_MUL_ACC_EN
            acc_q     <= {n{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            ready_q   <= (state_d == IDLE);
            done_q    <= (state_d == DONE);
`ifdef SEQ_MUL_ACC_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign ready_o   = ready_q;
    assign done_o    = done_q;
    assign product_o = product_q;
endmodule
